// File: rtl/rs_free_tracker.sv
// Reservation-station free-slot tracker.
// Keeps the free vector searched by the 3-way RS allocator. A committed
// allocation clears its slot on the next edge. An issued slot is set again
// two edges later, after passing through the one-cycle release register.
// Also keeps a registered free count, a low-water flag and a sticky
// protocol-error flag.
module rs_free_tracker #(
  parameter int WIDTH   = 32,
  parameter int CNTW    = $clog2(WIDTH + 1),
  parameter int LOWMARK = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic [WIDTH-1:0] newRsSelect0,
  input  logic [WIDTH-1:0] newRsSelect1,
  input  logic [WIDTH-1:0] newRsSelect2,
  input  logic [WIDTH-1:0] issueFree,
  input  logic             flush,
  output logic [WIDTH-1:0] bufFree,
  output logic [CNTW-1:0]  freeCount,
  output logic             lowWater,
  output logic             error
);

  logic [WIDTH-1:0] rel_pend;
  logic [WIDTH-1:0] alloc_m;
  logic [WIDTH-1:0] next_free;
  logic [CNTW-1:0]  next_cnt;
  logic             err_now;
  logic             multi_hot;
  logic             lane_overlap;

  // Committed allocation mask, next free vector and its popcount.
  // The count is taken from the next vector so that freeCount and bufFree
  // always describe the same cycle.
  always_comb begin
    alloc_m   = '0;
    next_free = '1;
    next_cnt  = '0;
    if (!stall) begin
      alloc_m = newRsSelect0 | newRsSelect1 | newRsSelect2;
    end
    if (!flush) begin
      // Release is ORed in last: if a slot is allocated and released in
      // the same cycle, the release wins and the slot stays free.
      next_free = (bufFree & ~alloc_m) | rel_pend;
    end
    for (int i = 0; i < WIDTH; i++) begin
      next_cnt = next_cnt + CNTW'(next_free[i]);
    end
  end

  // Protocol checks: an allocation of a busy slot, overlap between committed
  // lanes, a release of an already-free slot, and a select with more than
  // one bit set.
  always_comb begin
    multi_hot = ((newRsSelect0 & (newRsSelect0 - WIDTH'(1))) != '0) ||
                ((newRsSelect1 & (newRsSelect1 - WIDTH'(1))) != '0) ||
                ((newRsSelect2 & (newRsSelect2 - WIDTH'(1))) != '0);
    lane_overlap = !stall &&
                   (((newRsSelect0 & newRsSelect1) |
                     (newRsSelect0 & newRsSelect2) |
                     (newRsSelect1 & newRsSelect2)) != '0);
    err_now = !flush &&
              (((alloc_m & ~bufFree) != '0) ||
               lane_overlap ||
               ((rel_pend & bufFree & ~alloc_m) != '0) ||
               multi_hot);
  end

  // State registers. Reset has priority over flush, and flush discards any
  // release that is still pending.
  always_ff @(posedge clk) begin
    if (rst) begin
      bufFree   <= '1;
      rel_pend  <= '0;
      freeCount <= CNTW'(WIDTH);
      lowWater  <= 1'b0;
      error     <= 1'b0;
    end else begin
      bufFree   <= next_free;
      rel_pend  <= flush ? '0 : issueFree;
      freeCount <= next_cnt;
      lowWater  <= (next_cnt < CNTW'(LOWMARK));
      error     <= error | err_now;
    end
  end

endmodule
